sram_access_arbiter: RTL and testbench

//  Shares the single-port SRAM_controller between VGA reader, UART writer and MIC17 decompressor.

---
 rtl/sram_arb_pkg.sv | 34 +++
 rtl/sram_read_tag_pipe.sv | 37 +++
 rtl/sram_access_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Purpose : shared types, default widths and the priority helper for the
//           SRAM access arbiter and its read-tag pipeline.
// Contents: arb_owner_t  - SRAM owner / read-tag encoding
//           SRAM_*       - default address/data width, read latency, burst cap
//           arb_pick()   - fixed-priority selection VGA > UART > MIC
// ----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W    = 18;
  localparam int unsigned SRAM_DATA_W    = 16;
  localparam int unsigned SRAM_RD_LAT    = 2;
  localparam int unsigned SRAM_MAX_BURST = 16;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_VGA  = 2'd1,
    ARB_UART = 2'd2,
    ARB_MIC  = 2'd3
  } arb_owner_t;

  // Highest-priority active requester, or ARB_NONE when nobody asks.
  function automatic arb_owner_t arb_pick(input logic vga, input logic uart,
                                          input logic mic);
    arb_owner_t owner;
    owner = ARB_NONE;
    if (vga)       owner = ARB_VGA;
    else if (uart) owner = ARB_UART;
    else if (mic)  owner = ARB_MIC;
    return owner;
  endfunction

endpackage : sram_arb_pkg

// File: rtl/sram_read_tag_pipe.sv
// ----------------------------------------------------------------------------
// sram_read_tag_pipe
// Purpose : DEPTH-deep shift register of owner tags. A tag pushed alongside
//           an SRAM read address emerges exactly when that read's data is
//           valid, so read data is steered by who issued it, not by who owns
//           the SRAM at return time.
// Ports   : CLOCK_50_I  in   system clock
//           resetn      in   async active-low reset (flushes all stages)
//           i_tag       in   tag of the access issued this cycle
//           o_tag       out  tag of the access whose data returns this cycle
// ----------------------------------------------------------------------------
module sram_read_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = SRAM_RD_LAT
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  arb_owner_t i_tag,
  output arb_owner_t o_tag
);

  arb_owner_t r_stage [DEPTH];

  // Shift pipe; reset empties it so pre-reset reads never report valid.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= ARB_NONE;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule : sram_read_tag_pipe

// File: rtl/sram_access_arbiter.sv
// ----------------------------------------------------------------------------
// sram_access_arbiter
// Purpose : shares the single-port SRAM_controller between the VGA reader,
//           UART writer and MIC17 decompressor. Fixed priority
//           VGA > UART > MIC with sticky grants; UART/MIC ownership is capped
//           at MAX_BURST cycles while a higher-priority request waits. Reads
//           are tagged so returning data is flagged to the issuing requester.
// Optional: define SRAM_ARB_STATS_EN to add per-requester granted-cycle
//           counters (stat_clr, stat_vga_cnt, stat_uart_cnt, stat_mic_cnt).
// Ports   : CLOCK_50_I, resetn              clock, async active-low reset
//           vga_req/addr  -> vga_gnt, vga_rvalid         (read-only)
//           uart_req/addr/wdata/we_n -> uart_gnt         (write-only)
//           mic_req/addr/wdata/we_n  -> mic_gnt, mic_rvalid
//           SRAM_address, SRAM_write_data, SRAM_we_n     to SRAM_controller
//           stat_* (SRAM_ARB_STATS_EN only)              usage counters
// ----------------------------------------------------------------------------
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = SRAM_ADDR_W,
  parameter int unsigned DATA_W       = SRAM_DATA_W,
  parameter int unsigned READ_LATENCY = SRAM_RD_LAT,
  parameter int unsigned MAX_BURST    = SRAM_MAX_BURST
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              uart_req,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic              uart_we_n,
  output logic              uart_gnt,
  input  logic              mic_req,
  input  logic [ADDR_W-1:0] mic_addr,
  input  logic [DATA_W-1:0] mic_wdata,
  input  logic              mic_we_n,
  output logic              mic_gnt,
  output logic              mic_rvalid,
`ifdef SRAM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_vga_cnt,
  output logic [31:0]       stat_uart_cnt,
  output logic [31:0]       stat_mic_cnt,
`endif
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_owner_t       r_owner;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_vga_gnt;
  logic             r_uart_gnt;
  logic             r_mic_gnt;

  arb_owner_t       w_next_owner;
  arb_owner_t       w_issue_tag;
  arb_owner_t       w_exit_tag;
  logic             w_cap_hit;
  logic             w_owner_req;

  // Burst limit reached; >= keeps the cap effective after saturation so a
  // late higher-priority request still gets the bus within one cycle.
  assign w_cap_hit = (r_burst_cnt >= CNT_W'(MAX_BURST - 1));

  // Next owner: sticky while req holds, re-arbitrate on release or burst cap.
  always_comb begin
    w_next_owner = r_owner;
    case (r_owner)
      ARB_NONE: w_next_owner = arb_pick(vga_req, uart_req, mic_req);
      ARB_VGA: begin
        if (!vga_req) w_next_owner = arb_pick(1'b0, uart_req, mic_req);
      end
      ARB_UART: begin
        if (!uart_req)                w_next_owner = arb_pick(vga_req, 1'b0, mic_req);
        else if (w_cap_hit && vga_req) w_next_owner = ARB_VGA;
      end
      ARB_MIC: begin
        if (!mic_req) w_next_owner = arb_pick(vga_req, uart_req, 1'b0);
        else if (w_cap_hit && (vga_req || uart_req))
          w_next_owner = arb_pick(vga_req, uart_req, 1'b0);
      end
      default: w_next_owner = ARB_NONE;
    endcase
  end

  // Owner state, registered grants and burst counter.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_owner     <= ARB_NONE;
      r_burst_cnt <= '0;
      r_vga_gnt   <= 1'b0;
      r_uart_gnt  <= 1'b0;
      r_mic_gnt   <= 1'b0;
    end else begin
      r_owner    <= w_next_owner;
      r_vga_gnt  <= (w_next_owner == ARB_VGA);
      r_uart_gnt <= (w_next_owner == ARB_UART);
      r_mic_gnt  <= (w_next_owner == ARB_MIC);
      if (w_next_owner != r_owner)
        r_burst_cnt <= '0;
      else if ((r_owner != ARB_NONE) && (r_burst_cnt < CNT_W'(MAX_BURST)))
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end
  end

  assign vga_gnt  = r_vga_gnt;
  assign uart_gnt = r_uart_gnt;
  assign mic_gnt  = r_mic_gnt;

  // SRAM mux follows the current owner; a dropped req forces a read (no write).
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    w_owner_req     = 1'b0;
    case (r_owner)
      ARB_VGA: begin
        SRAM_address = vga_addr;
        w_owner_req  = vga_req;
      end
      ARB_UART: begin
        SRAM_address    = uart_addr;
        SRAM_write_data = uart_wdata;
        SRAM_we_n       = uart_we_n | ~uart_req;
        w_owner_req     = uart_req;
      end
      ARB_MIC: begin
        SRAM_address    = mic_addr;
        SRAM_write_data = mic_wdata;
        SRAM_we_n       = mic_we_n | ~mic_req;
        w_owner_req     = mic_req;
      end
      default: ;
    endcase
  end

  // Only genuine reads (owner asking, not writing) enter the tag pipe.
  assign w_issue_tag = (w_owner_req && SRAM_we_n) ? r_owner : ARB_NONE;

  sram_read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .i_tag      (w_issue_tag),
    .o_tag      (w_exit_tag)
  );

  assign vga_rvalid = (w_exit_tag == ARB_VGA);
  assign mic_rvalid = (w_exit_tag == ARB_MIC);

`ifdef SRAM_ARB_STATS_EN
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_stat_vga;
  logic [31:0] r_stat_uart;
  logic [31:0] r_stat_mic;

  // Granted-with-request cycle counters, saturating, synchronous clear.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_stat_vga  <= '0;
      r_stat_uart <= '0;
      r_stat_mic  <= '0;
    end else if (stat_clr) begin
      r_stat_vga  <= '0;
      r_stat_uart <= '0;
      r_stat_mic  <= '0;
    end else begin
      if ((r_owner == ARB_VGA) && vga_req && (r_stat_vga != STAT_MAX))
        r_stat_vga <= r_stat_vga + 32'd1;
      if ((r_owner == ARB_UART) && uart_req && (r_stat_uart != STAT_MAX))
        r_stat_uart <= r_stat_uart + 32'd1;
      if ((r_owner == ARB_MIC) && mic_req && (r_stat_mic != STAT_MAX))
        r_stat_mic <= r_stat_mic + 32'd1;
    end
  end

  assign stat_vga_cnt  = r_stat_vga;
  assign stat_uart_cnt = r_stat_uart;
  assign stat_mic_cnt  = r_stat_mic;
`endif

endmodule : sram_access_arbiter

// File: tb/tb_sram_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_access_arbiter
// Purpose : directed self-checking bench for sram_access_arbiter. Inputs are
//           driven and outputs sampled 2 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_sram_access_arbiter;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        vga_req;
  logic [17:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic        uart_req;
  logic [17:0] uart_addr;
  logic [15:0] uart_wdata;
  logic        uart_we_n;
  logic        uart_gnt;
  logic        mic_req;
  logic [17:0] mic_addr;
  logic [15:0] mic_wdata;
  logic        mic_we_n;
  logic        mic_gnt;
  logic        mic_rvalid;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
`ifdef SRAM_ARB_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_vga_cnt;
  logic [31:0] stat_uart_cnt;
  logic [31:0] stat_mic_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  sram_access_arbiter dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .vga_req         (vga_req),
    .vga_addr        (vga_addr),
    .vga_gnt         (vga_gnt),
    .vga_rvalid      (vga_rvalid),
    .uart_req        (uart_req),
    .uart_addr       (uart_addr),
    .uart_wdata      (uart_wdata),
    .uart_we_n       (uart_we_n),
    .uart_gnt        (uart_gnt),
    .mic_req         (mic_req),
    .mic_addr        (mic_addr),
    .mic_wdata       (mic_wdata),
    .mic_we_n        (mic_we_n),
    .mic_gnt         (mic_gnt),
    .mic_rvalid      (mic_rvalid),
`ifdef SRAM_ARB_STATS_EN
    .stat_clr        (stat_clr),
    .stat_vga_cnt    (stat_vga_cnt),
    .stat_uart_cnt   (stat_uart_cnt),
    .stat_mic_cnt    (stat_mic_cnt),
`endif
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  task automatic step();
    @(posedge CLOCK_50_I);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    vga_req = 1'b0;  vga_addr = '0;
    uart_req = 1'b0; uart_addr = '0; uart_wdata = '0; uart_we_n = 1'b1;
    mic_req = 1'b0;  mic_addr = '0;  mic_wdata = '0;  mic_we_n = 1'b1;
`ifdef SRAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state
    step(); step();
    chk("rst_gnts",   32'({vga_gnt, uart_gnt, mic_gnt}), 32'd0);
    chk("rst_rvalid", 32'({vga_rvalid, mic_rvalid}), 32'd0);
    chk("rst_we_n",   32'(SRAM_we_n), 32'd1);
    chk("rst_addr",   32'(SRAM_address), 32'd0);
    chk("rst_wdata",  32'(SRAM_write_data), 32'd0);
    resetn = 1'b1;
    step();

    // Lone MIC read: grant next cycle, rvalid two cycles after first grant
    mic_req = 1'b1; mic_we_n = 1'b1; mic_addr = 18'h00100;
    step();
    chk("mic1_gnt",    32'(mic_gnt), 32'd1);
    chk("mic1_vgagnt", 32'(vga_gnt), 32'd0);
    chk("mic1_addr",   32'(SRAM_address), 32'h100);
    chk("mic1_we_n",   32'(SRAM_we_n), 32'd1);
    chk("mic1_rv0",    32'(mic_rvalid), 32'd0);
    step();
    chk("mic1_gnt2",   32'(mic_gnt), 32'd1);
    chk("mic1_rv1",    32'(mic_rvalid), 32'd0);
    mic_req = 1'b0;
    step();
    chk("mic1_rel",    32'(mic_gnt), 32'd0);
    chk("mic1_rv2",    32'(mic_rvalid), 32'd1);
    step();
    chk("mic1_rv3",    32'(mic_rvalid), 32'd0);

    // All three request together: VGA wins and keeps the bus
    vga_req = 1'b1;  vga_addr = 18'h00200;
    uart_req = 1'b1; uart_addr = 18'h00010; uart_wdata = 16'hBEEF; uart_we_n = 1'b0;
    mic_req = 1'b1;  mic_we_n = 1'b1;
    step();
    chk("all_vga_gnt", 32'(vga_gnt), 32'd1);
    chk("all_others",  32'({uart_gnt, mic_gnt}), 32'd0);
    chk("all_addr",    32'(SRAM_address), 32'h200);
    chk("all_we_n",    32'(SRAM_we_n), 32'd1);
    chk("all_wdata",   32'(SRAM_write_data), 32'd0);
    chk("all_rv0",     32'(vga_rvalid), 32'd0);
    for (int i = 2; i <= 10; i++) begin
      step();
      chk("vga_hold_others", 32'({vga_gnt, uart_gnt, mic_gnt}), 32'b100);
      chk("vga_hold_rvalid", 32'(vga_rvalid), (i >= 3) ? 32'd1 : 32'd0);
    end
    vga_req = 1'b0;
    // UART takes over; VGA's last read still returns to VGA
    step();
    chk("uart_gnt",    32'({vga_gnt, uart_gnt, mic_gnt}), 32'b010);
    chk("uart_we_n",   32'(SRAM_we_n), 32'd0);
    chk("uart_wdata",  32'(SRAM_write_data), 32'hBEEF);
    chk("uart_addr",   32'(SRAM_address), 32'h10);
    chk("vga_rv_tail", 32'(vga_rvalid), 32'd1);
    chk("uart_mic_rv", 32'(mic_rvalid), 32'd0);
    step();
    chk("vga_rv_done", 32'(vga_rvalid), 32'd0);
    chk("uart_sticky", 32'({uart_gnt, mic_gnt}), 32'b10);
    chk("uart_no_rv",  32'({vga_rvalid, mic_rvalid}), 32'd0);
    uart_req = 1'b0; mic_req = 1'b0;
    step();
    chk("idle_gnts",   32'({vga_gnt, uart_gnt, mic_gnt}), 32'd0);
    chk("idle_we_n",   32'(SRAM_we_n), 32'd1);
    step();

    // MIC burst capped at 16 cycles by a waiting UART request
    mic_req = 1'b1; mic_we_n = 1'b1; mic_addr = 18'h00300;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("burst_mic_gnt", 32'({uart_gnt, mic_gnt}), 32'b01);
      if (i == 3) uart_req = 1'b1;
    end
    step();
    chk("burst_handover", 32'({uart_gnt, mic_gnt}), 32'b10);
    chk("burst_we_n",     32'(SRAM_we_n), 32'd0);
    chk("burst_rv15",     32'(mic_rvalid), 32'd1);
    step();
    chk("burst_rv16",     32'(mic_rvalid), 32'd1);
    chk("burst_uart_stk", 32'(uart_gnt), 32'd1);
    step();
    chk("burst_rv_end",   32'(mic_rvalid), 32'd0);
    uart_req = 1'b0;
    step();
    chk("mic_regain",     32'({uart_gnt, mic_gnt}), 32'b01);
    mic_req = 1'b0;
    step(); step();

    // VGA preempts MIC at grant cycle 16; MIC reads in flight still flagged to MIC
    mic_req = 1'b1; mic_we_n = 1'b1; mic_addr = 18'h00400;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("pre_mic_gnt", 32'({vga_gnt, mic_gnt}), 32'b01);
      if (i == 5) begin
        vga_req = 1'b1; vga_addr = 18'h00500;
      end
    end
    step();
    chk("pre_vga_gnt", 32'({vga_gnt, mic_gnt}), 32'b10);
    chk("pre_addr",    32'(SRAM_address), 32'h500);
    chk("pre_rv_a",    32'({vga_rvalid, mic_rvalid}), 32'b01);
    step();
    chk("pre_rv_b",    32'({vga_rvalid, mic_rvalid}), 32'b01);
    step();
    chk("pre_rv_c",    32'({vga_rvalid, mic_rvalid}), 32'b10);
    vga_req = 1'b0; mic_req = 1'b0;
    step(); step();

    // Reset with a MIC read in flight
    mic_req = 1'b1; mic_we_n = 1'b1; mic_addr = 18'h00100;
    step();
    chk("rmid_gnt",    32'(mic_gnt), 32'd1);
    step();
    resetn = 1'b0;
    #1;
    chk("rmid_gnts",   32'({vga_gnt, uart_gnt, mic_gnt}), 32'd0);
    chk("rmid_rvalid", 32'({vga_rvalid, mic_rvalid}), 32'd0);
    chk("rmid_sram",   32'({SRAM_address, SRAM_write_data, SRAM_we_n}), 32'd1);
    step();
    chk("rmid_rv_in",  32'(mic_rvalid), 32'd0);
    resetn = 1'b1;
    step();
    chk("rmid_regnt",  32'(mic_gnt), 32'd1);
    chk("rmid_rv_a",   32'(mic_rvalid), 32'd0);
    step();
    chk("rmid_rv_b",   32'(mic_rvalid), 32'd0);
    step();
    chk("rmid_rv_new", 32'(mic_rvalid), 32'd1);
    mic_req = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sram_access_arbiter
